// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
// Brings the PLL out of reset, waits for lock with a bounded number of
// timed attempts, qualifies lock stability, and only then releases the
// downstream synchronous reset. Lock loss while running triggers an
// automatic re-lock. Everything runs on the free-running reference clock.
module pll_lock_supervisor #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 7,
    parameter int CNT_W         = 8
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             pll_locked,
    input  logic             relock_req,
    output logic             pll_rst,
    output logic             sys_rst_n,
    output logic             ready,
    output logic             fail,
    output logic             lock_lost,
    output logic [CNT_W-1:0] relock_count,
    output logic [2:0]       state
);

    // One timer is shared by every timed state, so it is sized for the longest.
    localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_T   = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int TIMER_W = $clog2(MAX_T) + 1;
    localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [TIMER_W-1:0] RST_LAST     = TIMER_W'(RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [TIMER_W-1:0] timer_q;
    logic [TIMER_W-1:0] timer_d;
    logic [RETRY_W-1:0] retry_q;
    logic [RETRY_W-1:0] retry_d;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic               lock_lost_d;
    logic               pll_rst_d;
    logic               run_d;
    logic               fail_d;

    logic               sync_ff1;
    logic               locked_s;

    // Two-flop synchronizer: pll_locked is asynchronous to refclk.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            sync_ff1 <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync_ff1 <= pll_locked;
            locked_s <= sync_ff1;
        end
    end

    // Next-state, counters and next output values. A relock request in
    // WAIT_LOCK/STABLE wins over the lock indication; in RUN a lock loss wins
    // over the request so the event is still pulsed and counted.
    always_comb begin
        state_d     = state_q;
        retry_d     = retry_q;
        count_d     = count_q;
        lock_lost_d = 1'b0;
        case (state_q)
            S_RESET_PLL: begin
                if (timer_q == RST_LAST) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (relock_req) begin
                    state_d = S_RESET_PLL;
                end else if (locked_s) begin
                    state_d = S_STABLE;
                end else if (timer_q == TIMEOUT_LAST) begin
                    if (retry_q == RETRY_MAX) begin
                        state_d = S_FAIL;
                    end else begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = S_RESET_PLL;
                    end
                end
            end
            S_STABLE: begin
                if (relock_req) begin
                    state_d = S_RESET_PLL;
                end else if (!locked_s) begin
                    state_d = S_WAIT_LOCK;
                end else if (timer_q == STABLE_LAST) begin
                    state_d = S_RUN;
                    retry_d = '0;
                end
            end
            S_RUN: begin
                if (!locked_s) begin
                    state_d     = S_RESET_PLL;
                    lock_lost_d = 1'b1;
                    if (count_q != '1) count_d = count_q + CNT_W'(1);
                end else if (relock_req) begin
                    state_d = S_RESET_PLL;
                end
            end
            S_FAIL: begin
                if (relock_req) begin
                    state_d = S_RESET_PLL;
                    retry_d = '0;
                end
            end
            default: state_d = S_RESET_PLL;
        endcase

        // Timer restarts on every state entry and only advances in timed states,
        // so it can never wrap.
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (state_q == S_RESET_PLL || state_q == S_WAIT_LOCK || state_q == S_STABLE) begin
            timer_d = timer_q + TIMER_W'(1);
        end else begin
            timer_d = timer_q;
        end

        // Outputs are decoded from the next state so they change on the same
        // edge as the transition.
        pll_rst_d = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
        run_d     = (state_d == S_RUN);
        fail_d    = (state_d == S_FAIL);
    end

    // State register, counters and registered outputs.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state_q   <= S_RESET_PLL;
            timer_q   <= '0;
            retry_q   <= '0;
            count_q   <= '0;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
            fail      <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            count_q   <= count_d;
            pll_rst   <= pll_rst_d;
            sys_rst_n <= run_d;
            ready     <= run_d;
            fail      <= fail_d;
            lock_lost <= lock_lost_d;
        end
    end

    assign relock_count = count_q;
    assign state        = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: hand-derived vector table for the
// bring-up, glitch, timeout/fail, lock-loss and reset sequences, followed by
// randomized stimulus compared against a cycle-count reference model.
module tb_pll_lock_supervisor;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRIES   = 2;
    localparam int CNT_W         = 2;
    localparam int CNT_MAX       = (1 << CNT_W) - 1;
    localparam int N_RANDOM      = 4000;

    logic             refclk = 1'b0;
    logic             rst_n;
    logic             pll_locked;
    logic             relock_req;
    logic             pll_rst;
    logic             sys_rst_n;
    logic             ready;
    logic             fail;
    logic             lock_lost;
    logic [CNT_W-1:0] relock_count;
    logic [2:0]       state;

    // Clock generation.
    always #5 refclk = ~refclk;

    pll_lock_supervisor #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .MAX_RETRIES  (MAX_RETRIES),
        .CNT_W        (CNT_W)
    ) dut (
        .refclk      (refclk),
        .rst_n       (rst_n),
        .pll_locked  (pll_locked),
        .relock_req  (relock_req),
        .pll_rst     (pll_rst),
        .sys_rst_n   (sys_rst_n),
        .ready       (ready),
        .fail        (fail),
        .lock_lost   (lock_lost),
        .relock_count(relock_count),
        .state       (state)
    );

    // Observed vector: {state, pll_rst, sys_rst_n, ready, fail, lock_lost, relock_count}
    typedef struct {
        logic       rst_n;
        logic       pll_locked;
        logic       relock_req;
        int         n;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [9:0] pack(int st, bit pr, bit run, bit fl, bit ll, int cnt);
        logic [2:0] s3;
        logic [1:0] c2;
        s3 = 3'(st);
        c2 = 2'(cnt);
        return {s3, pr, run, run, fl, ll, c2};
    endfunction

    function automatic void add(bit r, bit l, bit q, int n, int st, bit pr, bit run, bit fl, bit ll, int cnt);
        vec_t v;
        v.rst_n      = r;
        v.pll_locked = l;
        v.relock_req = q;
        v.n          = n;
        v.exp        = pack(st, pr, run, fl, ll, cnt);
        vecs.push_back(v);
    endfunction

    // ---------------- reference model ----------------
    // Mode numbers are the published debug codes. cycles_in counts edges spent
    // in the current mode including the entry edge.
    int m_mode;
    int m_cycles_in;
    int m_retries;
    int m_losses;
    bit m_pulse;
    bit m_sync[$];

    task automatic model_edge(input bit r, input bit l, input bit q);
        bit ls;
        int nxt;
        ls = m_sync.pop_front();
        m_sync.push_back(l);
        if (!r) begin
            m_mode      = 0;
            m_cycles_in = 1;
            m_retries   = 0;
            m_losses    = 0;
            m_pulse     = 0;
            m_sync      = '{0, 0};
        end else begin
            m_pulse = 0;
            nxt     = m_mode;
            case (m_mode)
                0: if (m_cycles_in >= RST_CYCLES) nxt = 1;
                1: begin
                    if (q) nxt = 0;
                    else if (ls) nxt = 2;
                    else if (m_cycles_in >= LOCK_TIMEOUT) begin
                        if (m_retries >= MAX_RETRIES) nxt = 4;
                        else begin
                            m_retries++;
                            nxt = 0;
                        end
                    end
                end
                2: begin
                    if (q) nxt = 0;
                    else if (!ls) nxt = 1;
                    else if (m_cycles_in >= STABLE_CYCLES) begin
                        nxt       = 3;
                        m_retries = 0;
                    end
                end
                3: begin
                    if (!ls) begin
                        nxt     = 0;
                        m_pulse = 1;
                        m_losses++;
                    end else if (q) nxt = 0;
                end
                default: begin
                    if (q) begin
                        nxt       = 0;
                        m_retries = 0;
                    end
                end
            endcase
            if (nxt != m_mode) begin
                m_mode      = nxt;
                m_cycles_in = 1;
            end else begin
                m_cycles_in++;
            end
        end
    endtask

    function automatic logic [9:0] model_exp();
        int cnt;
        cnt = (m_losses > CNT_MAX) ? CNT_MAX : m_losses;
        return pack(m_mode, (m_mode == 0) || (m_mode == 4), m_mode == 3, m_mode == 4, m_pulse, cnt);
    endfunction

    // ---------------- driver and checker ----------------
    task automatic step(input logic r, input logic l, input logic q);
        rst_n      = r;
        pll_locked = l;
        relock_req = q;
        @(posedge refclk);
        #1;
        model_edge(r, l, q);
    endtask

    task automatic check(input string name, input logic [9:0] exp);
        logic [9:0] act;
        act = {state, pll_rst, sys_rst_n, ready, fail, lock_lost, relock_count};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: {state,pll_rst,sys_rst_n,ready,fail,lock_lost,cnt} got %b_%b%b%b%b%b_%b want %b_%b%b%b%b%b_%b",
                     name, act[9:7], act[6], act[5], act[4], act[3], act[2], act[1:0],
                     exp[9:7], exp[6], exp[5], exp[4], exp[3], exp[2], exp[1:0]);
        end
    endtask

    // Plain re-lock after a lock loss edge: PLL locks again straight away.
    function automatic void add_relock(int c);
        add(1, 1, 0, 1, 0, 1, 0, 0, 0, c);
        add(1, 1, 0, 3, 1, 0, 0, 0, 0, c);
        add(1, 1, 0, 1, 2, 0, 0, 0, 0, c);
        add(1, 1, 0, 7, 2, 0, 0, 0, 0, c);
        add(1, 1, 0, 1, 3, 0, 1, 0, 0, c);
    endfunction

    function automatic void fill_vectors();
        int c;
        // Normal bring-up, pll_locked rising during cycle 10.
        add(0, 0, 0, 2, 0, 1, 0, 0, 0, 0);
        add(1, 0, 0, 3, 0, 1, 0, 0, 0, 0);
        add(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 7, 1, 0, 0, 0, 0, 0);
        add(1, 1, 0, 2, 1, 0, 0, 0, 0, 0);
        add(1, 1, 0, 1, 2, 0, 0, 0, 0, 0);
        add(1, 1, 0, 7, 2, 0, 0, 0, 0, 0);
        add(1, 1, 0, 1, 3, 0, 1, 0, 0, 0);
        add(1, 1, 0, 3, 3, 0, 1, 0, 0, 0);
        // First lock loss, then re-lock with a one-cycle glitch during STABLE.
        add(1, 0, 0, 2, 3, 0, 1, 0, 0, 0);
        add(1, 0, 0, 1, 0, 1, 0, 0, 1, 1);
        add(1, 1, 0, 1, 0, 1, 0, 0, 0, 1);
        add(1, 1, 0, 3, 1, 0, 0, 0, 0, 1);
        add(1, 1, 0, 1, 2, 0, 0, 0, 0, 1);
        add(1, 1, 0, 2, 2, 0, 0, 0, 0, 1);
        add(1, 0, 0, 1, 2, 0, 0, 0, 0, 1);
        add(1, 1, 0, 1, 2, 0, 0, 0, 0, 1);
        add(1, 1, 0, 1, 1, 0, 0, 0, 0, 1);
        add(1, 1, 0, 1, 2, 0, 0, 0, 0, 1);
        add(1, 1, 0, 7, 2, 0, 0, 0, 0, 1);
        add(1, 1, 0, 1, 3, 0, 1, 0, 0, 1);
        // Three more losses: count saturates at 3.
        c = 1;
        for (int k = 0; k < 3; k++) begin
            add(1, 0, 0, 2, 3, 0, 1, 0, 0, c);
            c = (c < CNT_MAX) ? c + 1 : c;
            add(1, 0, 0, 1, 0, 1, 0, 0, 1, c);
            add_relock(c);
        end
        // rst_n low for one cycle mid-RUN.
        add(0, 1, 0, 1, 0, 1, 0, 0, 0, 0);
        add(1, 1, 0, 3, 0, 1, 0, 0, 0, 0);
        add(1, 1, 0, 1, 1, 0, 0, 0, 0, 0);
        add(1, 1, 0, 1, 2, 0, 0, 0, 0, 0);
        add(1, 1, 0, 7, 2, 0, 0, 0, 0, 0);
        add(1, 1, 0, 1, 3, 0, 1, 0, 0, 0);
        // Lock loss coincident with relock_req: counted as a loss.
        add(1, 0, 0, 2, 3, 0, 1, 0, 0, 0);
        add(1, 0, 1, 1, 0, 1, 0, 0, 1, 1);
        add_relock(1);
        // relock_req alone in RUN: no pulse, count unchanged; ignored in RESET_PLL.
        add(1, 1, 1, 1, 0, 1, 0, 0, 0, 1);
        add(1, 1, 0, 1, 0, 1, 0, 0, 0, 1);
        add(1, 1, 1, 1, 0, 1, 0, 0, 0, 1);
        add(1, 1, 0, 1, 0, 1, 0, 0, 0, 1);
        add(1, 1, 0, 1, 1, 0, 0, 0, 0, 1);
        add(1, 1, 0, 1, 2, 0, 0, 0, 0, 1);
        // Lock never asserted: three attempts, FAIL at cycle 71, relock_req restarts.
        add(0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        add(1, 0, 0, 3, 0, 1, 0, 0, 0, 0);
        for (int a = 0; a < 3; a++) begin
            add(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
            add(1, 0, 0, 19, 1, 0, 0, 0, 0, 0);
            if (a < 2) begin
                add(1, 0, 0, 1, 0, 1, 0, 0, 0, 0);
                add(1, 0, 0, 3, 0, 1, 0, 0, 0, 0);
            end
        end
        add(1, 0, 0, 1, 4, 1, 0, 1, 0, 0);
        add(1, 0, 0, 5, 4, 1, 0, 1, 0, 0);
        add(1, 0, 1, 1, 0, 1, 0, 0, 0, 0);
        add(1, 0, 0, 3, 0, 1, 0, 0, 0, 0);
        add(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    endfunction

    // Stimulus, checking and final report.
    initial begin
        bit lvl;
        int hold;
        bit r;
        bit q;
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        m_sync     = '{0, 0};
        m_mode     = 0;
        m_cycles_in = 1;
        m_retries  = 0;
        m_losses   = 0;
        m_pulse    = 0;

        fill_vectors();
        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].n; k++) step(vecs[i].rst_n, vecs[i].pll_locked, vecs[i].relock_req);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        step(1'b0, 1'b0, 1'b0);
        check("rand_reset", model_exp());
        lvl  = 1'b0;
        hold = 0;
        for (int i = 0; i < N_RANDOM; i++) begin
            if (hold == 0) begin
                lvl  = ~lvl;
                hold = lvl ? $urandom_range(10, 120) : $urandom_range(1, 30);
            end
            hold--;
            r = ($urandom_range(0, 799) != 0);
            q = ($urandom_range(0, 149) == 0);
            step(r, lvl, q);
            check($sformatf("rand%0d", i), model_exp());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Control-side counterpart of the PLL wrapper. Drives the PLL `rst` input and consumes its `locked` output.
- Sequences PLL reset, waits for lock with a timeout and bounded retries, and qualifies lock stability.
- Releases a synchronous system reset only after lock is qualified.
- Detects lock loss during operation and automatically re-locks.
- Runs on the free-running reference clock, never on the PLL output clock.

Parameters:
- RST_CYCLES, 16: cycles `pll_rst` is held high per reset attempt (≥1).
- LOCK_TIMEOUT, 50000: cycles allowed in WAIT_LOCK before an attempt fails (1 ms at 50 MHz).
- STABLE_CYCLES, 1024: consecutive synchronized-locked cycles required before release.
- MAX_RETRIES, 7: timeouts tolerated before FAIL. Total attempts = MAX_RETRIES+1.
- CNT_W, 8: width of `relock_count`.

Ports:
- refclk, in, 1: reference clock, free-running.
- rst_n, in, 1: synchronous active-low reset.
- pll_locked, in, 1: PLL locked. Asynchronous to refclk; synchronized internally.
- relock_req, in, 1: level/pulse software request to re-run the PLL bring-up.
- pll_rst, out, 1: active-high reset to the PLL.
- sys_rst_n, out, 1: active-low reset for the downstream logic. High only in RUN.
- ready, out, 1: high only in RUN.
- fail, out, 1: high only in FAIL.
- lock_lost, out, 1: one-cycle pulse on lock loss in RUN.
- relock_count, out, CNT_W: count of lock-loss events; saturates at all-ones.
- state, out, 3: current state encoding, for debug.

Behaviour:
- Synchronizer:
  - `pll_locked` passes through a 2-FF synchronizer; its output is `locked_s`.
  - Both FFs reset to 0.
  - `locked_s` lags `pll_locked` by 2 cycles.
- Reset (rst_n low at a refclk edge):
  - state = RESET_PLL, timer = 0, retry_cnt = 0, relock_count = 0.
  - Outputs: pll_rst = 1, sys_rst_n = 0, ready = 0, fail = 0, lock_lost = 0.
  - Applies at any point, including mid-RUN.
- State encodings: RESET_PLL = 0, WAIT_LOCK = 1, STABLE = 2, RUN = 3, FAIL = 4. Undefined codes → RESET_PLL.
- All outputs are registered. The timer clears on every state entry.
- RESET_PLL:
  - pll_rst = 1.
  - After exactly RST_CYCLES cycles in the state → WAIT_LOCK.
- WAIT_LOCK:
  - pll_rst = 0.
  - locked_s = 1 → STABLE.
  - Otherwise, when timer = LOCK_TIMEOUT-1:
    - retry_cnt == MAX_RETRIES → FAIL.
    - Else retry_cnt++ and → RESET_PLL.
- STABLE:
  - locked_s = 0 → WAIT_LOCK. Timer restarts; no retry increment.
  - timer = STABLE_CYCLES-1 with locked_s = 1 → RUN, retry_cnt = 0.
- RUN:
  - sys_rst_n = 1, ready = 1.
  - locked_s = 0 → RESET_PLL, with lock_lost = 1 for one cycle, relock_count += 1 (saturating), sys_rst_n = 0.
  - All three changes appear on the same edge as the transition.
- FAIL:
  - pll_rst = 1 (held), fail = 1.
  - Exits only on rst_n or relock_req.
  - relock_req → retry_cnt = 0 and → RESET_PLL.
- relock_req in WAIT_LOCK, STABLE or RUN → RESET_PLL. No lock_lost pulse, no count change.
- relock_req in RESET_PLL is ignored; the timer is not restarted.
- Priority (RUN): lock loss beats relock_req in the same cycle. The event is treated as a lock loss, so it pulses and counts.
- Priority (WAIT_LOCK): locked_s = 1 beats timeout in the same cycle → STABLE.
- Timer width: $clog2 of max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) + 1. The timer never wraps in any state.

Test Plan (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2, CNT_W=2; cycle 0 = first edge with rst_n high):
- Normal bring-up: pll_locked rises at cycle 10.
  - pll_rst = 1 for cycles 0-3, 0 from cycle 4.
  - sys_rst_n and ready rise at cycle 21 (2 sync + 1 entry + 8 stable), relock_count = 0.
- Glitch in STABLE: pll_locked low for 1 cycle mid-STABLE.
  - state returns to 1, then re-enters 2; sys_rst_n stays 0 until 8 fresh stable cycles.
  - No lock_lost pulse; pll_rst stays 0.
- Lock never asserted:
  - pll_rst re-pulses 4 cycles after each 20-cycle wait, 3 attempts in total.
  - fail = 1 and state = 4 at cycle 71; pll_rst stays 1.
  - relock_req pulse then restarts the sequence from RESET_PLL.
- Lock loss in RUN: drop pll_locked.
  - Two cycles later, on a single edge: lock_lost is a 1-cycle pulse, relock_count 0→1, sys_rst_n = 0, pll_rst = 1.
  - Re-lock then succeeds.
  - Repeat 4 times: relock_count saturates at 3.
- Same-cycle relock_req and lock loss in RUN: lock_lost pulses and relock_count increments.
  - Separately, relock_req alone in RUN → RESET_PLL with no pulse and unchanged count.
- rst_n low for 1 cycle during RUN: next edge gives pll_rst = 1, sys_rst_n = 0, ready = 0, relock_count = 0, state = 0.
